program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the processor's program memory: receives a framed byte stream (e.g. from a UART receiver), packs bytes into 32-bit instruction words and writes them sequentially into program RAM from address 0.
- Holds the processor in hold (cpu_hold) while loading.
- Reports completion or a framing/checksum error.
- Sits between the serial front end and the program RAM write port.

Parameters:
ADDR_W, 10, program RAM address width
DEPTH, 1024, number of 32-bit words in program RAM (max loadable count)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
byte_in  in  8  incoming stream byte
byte_valid  in  1  byte_in valid
byte_ready  out  1  loader accepts byte this cycle (transfer = valid & ready)
ram_we  out  1  program RAM write enable, one-cycle pulse per word
ram_addr  out  ADDR_W  program RAM write address
ram_wdata  out  32  word to write
cpu_hold  out  1  high while a frame is in progress
load_done  out  1  one-cycle pulse, frame loaded and checksum good
load_error  out  1  sticky error flag, cleared by next accepted SYNC_BYTE or reset
words_loaded  out  ADDR_W+1  count of words written in current/last frame

Behaviour:
- Reset (async, rst_n low): state IDLE; byte_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=0, load_done=0, load_error=0, words_loaded=0; internal checksum, byte index and word count cleared. Reset mid-frame abandons the frame; words already written stay in RAM.
- Frame format: SYNC_BYTE, CNT_HI, CNT_LO (16-bit word count N, big-endian), N*4 payload bytes (each word MSB byte first), CHK byte = XOR of all payload bytes.
- byte_ready=1 in IDLE, HDR_HI, HDR_LO, DATA, CHECK; 0 in WRITE, DONE, ERROR. Only transfers (valid & ready) advance state.
- States and transitions:
  - IDLE: a transfer equal to SYNC_BYTE goes to HDR_HI, clears load_error/words_loaded/checksum, sets ram_addr=0 and cpu_hold=1. Other bytes are discarded, with no error.
  - HDR_HI: latches the upper count byte, then goes to HDR_LO.
  - HDR_LO: latches the lower count byte. N=0 goes to CHECK. N>DEPTH goes to ERROR. Otherwise goes to DATA.
  - DATA: shifts the byte into the assembly register (first byte lands in [31:24]) and XORs it into the checksum. On the 4th byte, goes to WRITE.
  - WRITE: for exactly one cycle, ram_we=1 with ram_wdata=assembled word and ram_addr=current address. The next cycle increments ram_addr and words_loaded. If words_loaded now equals N, goes to CHECK; else returns to DATA.
  - CHECK: a transfer equal to the checksum goes to DONE; a mismatch goes to ERROR.
  - DONE: one cycle. load_done=1, cpu_hold drops to 0 the same cycle, then returns to IDLE.
  - ERROR: one cycle. load_error=1 (sticky), cpu_hold drops to 0, then returns to IDLE.
- Latency: 4th payload byte accepted in cycle t → ram_we high in cycle t+1 → byte_ready high again in t+2.
- ram_addr wraps are impossible because N≤DEPTH is enforced. With N=DEPTH, the final address is DEPTH-1 and ram_addr is not incremented past it (held).
- byte_valid while byte_ready=0: the byte is not consumed; the source must hold it.
- A SYNC_BYTE value inside header/payload/checksum is treated as data, not a resync.
- ram_we is never asserted outside WRITE.

Decomposition:
- Shared package (processor-wide) holds:
  - the state encoding typedef (IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHECK, DONE, ERROR);
  - SYNC_BYTE and the program RAM DEPTH/ADDR_W constants, shared with the program RAM.
- One natural sub-module: word_packer. It contains the 4-byte shift register, the 2-bit byte index and the running XOR checksum, and outputs word_ready. The FSM stays in program_loader.

Test Plan:
- Send A5 00 02 11 22 33 44 55 66 77 88 CHK=88 → two ram_we pulses: addr0=32'h11223344, addr1=32'h55667788; load_done pulse; words_loaded=2; cpu_hold low afterwards.
- Same frame with CHK=00 → both words written, no load_done, load_error=1, cpu_hold low. The next A5 clears load_error.
- Send A5 04 01 (N=1025) → ERROR immediately after CNT_LO, no ram_we, load_error=1.
- Send 00 FF 12 A5 00 00 00 → leading junk ignored; N=0 frame with CHK=00 gives load_done and zero writes.
- Hold byte_valid=1 continuously through a 1-word frame → byte_ready drops in the WRITE cycle, no byte is lost or duplicated, word correct.
- Assert rst_n=0 after two payload bytes of a 1-word frame → all outputs return to reset values immediately and no ram_we occurs. A fresh frame afterwards loads correctly at addr 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Processor-wide constants shared by the program loader and program RAM,
// plus the loader state encoding.
package program_loader_pkg;

  localparam int         PROG_ADDR_W    = 10;
  localparam int         PROG_DEPTH     = 1024;
  localparam logic [7:0] PROG_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } ld_state_e;

endpackage

// File: rtl/program_loader_word_packer.sv
// Packs payload bytes MSB-first into a 32-bit word and keeps the running
// XOR checksum of every payload byte in the frame.
module program_loader_word_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [7:0]  chk_o,
  output logic        word_ready_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic [7:0]  chk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
      chk_q  <= '0;
    end else if (clr_i) begin
      idx_q  <= '0;
      chk_q  <= '0;
    end else if (shift_i) begin
      word_q <= {word_q[23:0], byte_i};
      idx_q  <= idx_q + 2'd1;
      chk_q  <= chk_q ^ byte_i;
    end
  end

  // High on the transfer that completes a word; word_o holds it next cycle.
  assign word_ready_o = shift_i & (idx_q == 2'd3);
  assign word_o       = word_q;
  assign chk_o        = chk_q;

endmodule

// File: rtl/program_loader.sv
// Program RAM writer: parses SYNC/count/payload/checksum frames, writes packed
// words from address 0 and holds the CPU while a frame is in progress.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_W    = PROG_ADDR_W,
  parameter int         DEPTH     = PROG_DEPTH,
  parameter logic [7:0] SYNC_BYTE = PROG_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  ld_state_e         state_q;
  logic              ready_q, we_q, hold_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   words_q;
  logic [15:0]       cnt_q;

  logic              xfer, sync_hit, shift, word_ready;
  logic [31:0]       pk_word;
  logic [7:0]        pk_chk;
  logic [15:0]       cnt_d;
  logic [ADDR_W:0]   words_d;

  assign xfer     = byte_valid & ready_q;
  assign sync_hit = xfer && (state_q == ST_IDLE) && (byte_in == SYNC_BYTE);
  assign shift    = xfer && (state_q == ST_DATA);
  assign cnt_d    = {cnt_q[15:8], byte_in};
  assign words_d  = words_q + (ADDR_W+1)'(1);

  program_loader_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (sync_hit),
    .shift_i      (shift),
    .byte_i       (byte_in),
    .word_o       (pk_word),
    .chk_o        (pk_chk),
    .word_ready_o (word_ready)
  );

  // byte_ready is registered: it drops on entry to WRITE/DONE/ERROR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      words_q <= '0;
      cnt_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sync_hit) begin
            state_q <= ST_HDR_HI;
            err_q   <= 1'b0;
            words_q <= '0;
            addr_q  <= '0;
            hold_q  <= 1'b1;
          end
        end
        ST_HDR_HI: begin
          if (xfer) begin
            cnt_q[15:8] <= byte_in;
            state_q     <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (xfer) begin
            cnt_q <= cnt_d;
            if (cnt_d == 16'd0) begin
              state_q <= ST_CHECK;
            end else if ({16'd0, cnt_d} > 32'(DEPTH)) begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
              hold_q  <= 1'b0;
              ready_q <= 1'b0;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_ready) begin
            state_q <= ST_WRITE;
            we_q    <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_WRITE: begin
          words_q <= words_d;
          // The last slot of a full-depth frame keeps its address.
          if (addr_q != ADDR_W'(DEPTH-1)) addr_q <= addr_q + 1'b1;
          state_q <= (16'(words_d) == cnt_q) ? ST_CHECK : ST_DATA;
        end
        ST_CHECK: begin
          if (xfer) begin
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            if (byte_in == pk_chk) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        ST_ERROR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready   = ready_q;
  assign ram_we       = we_q;
  assign ram_addr     = addr_q;
  assign ram_wdata    = pk_word;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of whole frames plus hand-written
// sequences for latency, sticky error clear, full-depth frame and mid-frame reset.
module tb_program_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Write/pulse monitor, sampled on the falling edge
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int                done_cnt = 0;
  int                rdy_viol = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        wa_q.push_back(ram_addr);
        wd_q.push_back(ram_wdata);
        if (byte_ready) rdy_viol++;
      end
      if (load_done) done_cnt++;
    end
  end

  typedef struct {
    string        name;
    int           len;
    logic [95:0]  bytes;   // right-justified, first byte sent is the leftmost
    int           nwr;
    logic [31:0]  w0;
    logic [31:0]  w1;
    int           done;
    logic         err;
    int           words;
  } vec_t;

  vec_t vt[6];

  function automatic vec_t mk(string n, int len, logic [95:0] by, int nwr,
                              logic [31:0] w0, logic [31:0] w1, int d,
                              logic e, int w);
    vec_t v;
    v.name = n; v.len = len; v.bytes = by; v.nwr = nwr;
    v.w0 = w0; v.w1 = w1; v.done = d; v.err = e; v.words = w;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    rdy_viol = 0;
  endtask

  // Presents b and returns #1 after the edge that accepted it; valid stays high.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=ready_low required=ready_high");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic finish_frame();
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    clear_mon();
    for (int i = 0; i < v.len; i++) send_byte(v.bytes[8*(v.len-1-i) +: 8]);
    finish_frame();
    check({v.name, "_nwr"}, 64'(wa_q.size()), 64'(v.nwr));
    for (int k = 0; k < v.nwr && k < wa_q.size(); k++) begin
      check({v.name, "_addr"}, 64'(wa_q[k]), 64'(k));
      check({v.name, "_data"}, 64'(wd_q[k]), 64'((k == 0) ? v.w0 : v.w1));
    end
    check({v.name, "_done"}, 64'(done_cnt), 64'(v.done));
    check({v.name, "_err"}, 64'(load_error), 64'(v.err));
    check({v.name, "_words"}, 64'(words_loaded), 64'(v.words));
    check({v.name, "_hold"}, 64'(cpu_hold), 64'(0));
    check({v.name, "_ready"}, 64'(byte_ready), 64'(1));
    check({v.name, "_rdy_in_write"}, 64'(rdy_viol), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  chk;
    logic [31:0] w;
    int          bad;

    vt[0] = mk("two_words", 12,
               96'({8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'h55, 8'h66, 8'h77, 8'h88, 8'h88}),
               2, 32'h11223344, 32'h55667788, 1, 1'b0, 2);
    vt[1] = mk("bad_chk", 12,
               96'({8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'h55, 8'h66, 8'h77, 8'h88, 8'h00}),
               2, 32'h11223344, 32'h55667788, 0, 1'b1, 2);
    vt[2] = mk("too_long", 3, 96'({8'hA5, 8'h04, 8'h01}),
               0, 32'h0, 32'h0, 0, 1'b1, 0);
    vt[3] = mk("junk_n0", 7,
               96'({8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00}),
               0, 32'h0, 32'h0, 1, 1'b0, 0);
    vt[4] = mk("one_word", 8,
               96'({8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}),
               1, 32'hDEADBEEF, 32'h0, 1, 1'b0, 1);
    vt[5] = mk("sync_in_data", 8,
               96'({8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00}),
               1, 32'hA5A5A5A5, 32'h0, 1, 1'b0, 1);

    // Reset values while rst_n is low
    #2;
    check("reset_ready", 64'(byte_ready), 64'(0));
    check("reset_outs",
          64'({ram_we, cpu_hold, load_done, load_error, ram_addr, words_loaded}),
          64'(0));
    check("reset_wdata", 64'(ram_wdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Write latency, stall in WRITE with valid held, sticky error then clear
    clear_mon();
    send_byte(8'hA5);
    check("hold_after_sync", 64'(cpu_hold), 64'(1));
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    check("lat_we", 64'({ram_we, byte_ready}), 64'(2'b10));
    check("lat_addr_data", 64'({ram_addr, ram_wdata}), 64'({10'd0, 32'hCAFEBABE}));
    @(posedge clk); #1;
    check("lat_after_we", 64'({ram_we, byte_ready}), 64'(2'b01));
    check("lat_words", 64'(words_loaded), 64'(1));
    send_byte(8'hFF);   // correct checksum would be 8'h30
    finish_frame();
    check("lat_nwr", 64'(wa_q.size()), 64'(1));
    check("err_set", 64'({load_error, cpu_hold, 7'(done_cnt)}), 64'({2'b10, 7'd0}));
    repeat (5) @(negedge clk);
    check("err_sticky", 64'(load_error), 64'(1));
    send_byte(8'hA5);
    check("err_cleared_by_sync", 64'({load_error, cpu_hold}), 64'(2'b01));
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    finish_frame();
    check("after_clear_done", 64'(done_cnt), 64'(1));

    // Full-depth frame: N = DEPTH, address held at DEPTH-1
    clear_mon();
    chk = 8'h00;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'hC0DE0000 | 32'(i);
      for (int j = 0; j < 4; j++) begin
        chk = chk ^ w[31-8*j -: 8];
        send_byte(w[31-8*j -: 8]);
      end
    end
    send_byte(chk);
    finish_frame();
    check("max_nwr", 64'(wa_q.size()), 64'(DEPTH));
    bad = 0;
    for (int k = 0; k < wa_q.size(); k++)
      if (wa_q[k] !== ADDR_W'(k) || wd_q[k] !== (32'hC0DE0000 | 32'(k))) bad++;
    check("max_content", 64'(bad), 64'(0));
    check("max_addr_held", 64'(ram_addr), 64'(DEPTH-1));
    check("max_words", 64'(words_loaded), 64'(DEPTH));
    check("max_done", 64'({7'(done_cnt), load_error}), 64'({7'd1, 1'b0}));

    // Reset after two payload bytes abandons the frame
    clear_mon();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    byte_valid = 1'b0;
    #1;
    check("midrst_outs",
          64'({byte_ready, ram_we, cpu_hold, load_done, load_error, ram_addr, words_loaded}),
          64'(0));
    check("midrst_wdata", 64'(ram_wdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_no_write", 64'(wa_q.size()), 64'(0));
    run_vec(vt[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
